// File: rtl/alu_exec_if.sv
// Handshake bundle between the register-read stage and the ALU execute unit.
// master drives operations and consumes results; slave is the execute unit.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      op;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [1:0]      ALUOp;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      alu_ctrl;

  modport master (
    output in_valid, op, func3, func7, ALUOp, a, b, out_ready,
    input  in_ready, out_valid, result, zero, alu_ctrl
  );

  modport slave (
    input  in_valid, op, func3, func7, ALUOp, a, b, out_ready,
    output in_ready, out_valid, result, zero, alu_ctrl
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I decode-plus-execute stage with a registered valid/ready result.
// Define ALU_MULDIV_EN to add the iterative RV32M multiply/divide path.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_exec_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  state_t          state, state_d, launch_state;
  logic [4:0]      ctrl_d, ctrl_q;
  logic [XLEN-1:0] alu_res, result_q;
  logic            zero_q, busy, multi, accept;
  logic [SHW-1:0]  sh;
  logic            unused_inputs;

  assign unused_inputs = ^{bus.op, bus.func7};
  assign sh            = bus.b[SHW-1:0];

  always_comb begin
    ctrl_d = 5'b00000;
    unique case (bus.ALUOp)
      2'b00: ctrl_d = 5'b00000;
      2'b01: ctrl_d = 5'b00001;
      2'b11: ctrl_d = 5'b01000;
      default: begin
        unique case (bus.func3)
          3'b000:  ctrl_d = (bus.op[5] && bus.func7[5]) ? 5'b00001 : 5'b00000;
          3'b001:  ctrl_d = 5'b00110;
          3'b010:  ctrl_d = 5'b00101;
          3'b011:  ctrl_d = 5'b00111;
          3'b100:  ctrl_d = 5'b00100;
          3'b101:  ctrl_d = bus.func7[5] ? 5'b01010 : 5'b01001;
          3'b110:  ctrl_d = 5'b00011;
          default: ctrl_d = 5'b00010;
        endcase
`ifdef ALU_MULDIV_EN
        if (bus.op[5] && bus.func7 == 7'b0000001)
          ctrl_d = {2'b10, bus.func3};
`endif
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (ctrl_d)
      5'b00000: alu_res = bus.a + bus.b;
      5'b00001: alu_res = bus.a - bus.b;
      5'b00010: alu_res = bus.a & bus.b;
      5'b00011: alu_res = bus.a | bus.b;
      5'b00100: alu_res = bus.a ^ bus.b;
      5'b00101: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      5'b00110: alu_res = bus.a << sh;
      5'b00111: alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      5'b01000: alu_res = bus.b;
      5'b01001: alu_res = bus.a >> sh;
      5'b01010: alu_res = $signed(bus.a) >>> sh;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Shared iterative datapath: acc holds {hi,lo} of the product, or {remainder,quotient}.
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0]   opnd, md_a, md_res, mag_a, mag_b, quo, rem;
  logic [XLEN:0]     sum, rs, diff;
  logic [CW-1:0]     cnt;
  logic [2:0]        md_f3;
  logic              md_neg, md_div0, a_neg, b_neg, a_signed, b_signed, md_done;

  assign busy     = (state == BUSY);
  assign multi    = ctrl_d[4];
  assign md_done  = (cnt == CW'(XLEN));
  assign a_signed = !(bus.func3 == 3'b011 || bus.func3 == 3'b101 || bus.func3 == 3'b111);
  assign b_signed = (bus.func3 == 3'b000 || bus.func3 == 3'b001 ||
                     bus.func3 == 3'b100 || bus.func3 == 3'b110);
  assign a_neg    = a_signed && bus.a[XLEN-1];
  assign b_neg    = b_signed && bus.b[XLEN-1];
  assign mag_a    = a_neg ? -bus.a : bus.a;
  assign mag_b    = b_neg ? -bus.b : bus.b;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rs       = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = rs - {1'b0, opnd};
    acc_step = '0;
    if (!md_f3[2])
      acc_step = {sum, acc[XLEN-1:1]};
    else if (!diff[XLEN])
      acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Operands were made non-negative at accept; apply the sign and the div-by-zero rule here.
  always_comb begin
    prod   = md_neg ? -acc : acc;
    quo    = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    md_res = '0;
    unique case (md_f3)
      3'b000:         md_res = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         md_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: md_res = md_div0 ? '1 : (md_neg ? -quo : quo);
      default:        md_res = md_div0 ? md_a : (md_neg ? -rem : rem);
    endcase
  end

  always_comb begin
    launch_state = multi ? BUSY : HOLD;
  end
`else
  assign busy  = 1'b0;
  assign multi = 1'b0;

  always_comb begin
    launch_state = HOLD;
  end
`endif

  assign bus.in_ready = !busy && (state != HOLD || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept) state_d = launch_state;
      HOLD: if (bus.out_ready) state_d = accept ? launch_state : IDLE;
`ifdef ALU_MULDIV_EN
      BUSY: if (md_done) state_d = HOLD;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ctrl_q   <= '0;
`ifdef ALU_MULDIV_EN
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      md_a     <= '0;
      md_f3    <= '0;
      md_neg   <= 1'b0;
      md_div0  <= 1'b0;
`endif
    end else begin
      state <= state_d;
      if (accept && !multi) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        ctrl_q   <= ctrl_d;
      end
`ifdef ALU_MULDIV_EN
      if (accept && multi) begin
        cnt     <= '0;
        md_f3   <= bus.func3;
        md_a    <= bus.a;
        md_div0 <= (bus.b == '0);
        md_neg  <= (bus.func3[2] && bus.func3[1]) ? a_neg : (a_neg ^ b_neg);
        acc     <= {{XLEN{1'b0}}, (bus.func3[2] ? mag_a : mag_b)};
        opnd    <= bus.func3[2] ? mag_b : mag_a;
      end else if (busy) begin
        if (md_done) begin
          result_q <= md_res;
          zero_q   <= (md_res == '0);
          ctrl_q   <= {2'b10, md_f3};
        end else begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.out_valid = (state == HOLD);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.alu_ctrl  = ctrl_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector bench for alu_exec_unit: decode table, handshake stalls, reset,
// and (when ALU_MULDIV_EN is defined) the multi-cycle multiply/divide path.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  ctrl;
  } vec_t;

  vec_t vecs[16];

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] aluop, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.ALUOp    = aluop;
    bus.op       = op;
    bus.func3    = f3;
    bus.func7    = f7;
    bus.a        = a;
    bus.b        = b;
  endtask

`ifdef ALU_MULDIV_EN
  task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    apply_stimulus(2'b10, OP_R, f3, 7'b0000001, a, b);
    tick();
    bus.in_valid = 1'b0;
    check_output({name, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    check_output({name, " latency"}, 32'(n), 32'd33);
    check_output({name, " result"}, bus.result, exp);
    check_output({name, " ctrl"}, 32'(bus.alu_ctrl), {27'd0, 2'b10, f3});
    tick();
  endtask
`endif

  initial begin
    vecs[0]  = '{"sub r",    2'b10, OP_R, 3'b000, 7'b0100000, 32'd5,        32'd7,        32'hFFFFFFFE, 5'b00001};
    vecs[1]  = '{"sra r",    2'b10, OP_R, 3'b101, 7'b0100000, 32'h80000000, 32'd4,        32'hF8000000, 5'b01010};
    vecs[2]  = '{"srl r",    2'b10, OP_R, 3'b101, 7'b0000000, 32'h80000000, 32'd4,        32'h08000000, 5'b01001};
    vecs[3]  = '{"slt",      2'b10, OP_R, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd1,        5'b00101};
    vecs[4]  = '{"sltu",     2'b10, OP_R, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b00111};
    vecs[5]  = '{"aluop add",2'b00, OP_R, 3'b111, 7'b0100000, 32'd3,        32'd4,        32'd7,        5'b00000};
    vecs[6]  = '{"aluop sub",2'b01, OP_R, 3'b000, 7'b0000000, 32'd3,        32'd4,        32'hFFFFFFFF, 5'b00001};
    vecs[7]  = '{"passb",    2'b11, OP_R, 3'b000, 7'b0000000, 32'd3,        32'h12345000, 32'h12345000, 5'b01000};
    vecs[8]  = '{"xor",      2'b10, OP_R, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'b00100};
    vecs[9]  = '{"or",       2'b10, OP_R, 3'b110, 7'b0000000, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 5'b00011};
    vecs[10] = '{"and",      2'b10, OP_R, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00010};
    vecs[11] = '{"sll 31",   2'b10, OP_R, 3'b001, 7'b0000000, 32'd1,        32'd31,       32'h80000000, 5'b00110};
    vecs[12] = '{"sll mask", 2'b10, OP_R, 3'b001, 7'b0000000, 32'd3,        32'h00000021, 32'd6,        5'b00110};
    vecs[13] = '{"addi f7",  2'b10, OP_I, 3'b000, 7'b0100000, 32'd5,        32'd7,        32'd12,       5'b00000};
    vecs[14] = '{"add wrap", 2'b10, OP_R, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b00000};
    vecs[15] = '{"srai",     2'b10, OP_I, 3'b101, 7'b0100000, 32'h80000000, 32'h00000404, 32'hF8000000, 5'b01010};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ALUOp     = 2'b00;
    bus.op        = '0;
    bus.func3     = '0;
    bus.func7     = '0;
    bus.a         = '0;
    bus.b         = '0;
    tick();
    tick();
    check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset result", bus.result, 32'd0);
    check_output("reset zero", 32'(bus.zero), 32'd0);
    check_output("reset ctrl", 32'(bus.alu_ctrl), 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("reset in_ready", 32'(bus.in_ready), 32'd1);

    // Vector table, issued back to back with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].aluop, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
      check_output({vecs[i].name, " in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      check_output({vecs[i].name, " valid"}, 32'(bus.out_valid), 32'd1);
      check_output({vecs[i].name, " result"}, bus.result, vecs[i].res);
      check_output({vecs[i].name, " ctrl"}, 32'(bus.alu_ctrl), 32'(vecs[i].ctrl));
      check_output({vecs[i].name, " zero"}, 32'(bus.zero), 32'(vecs[i].res == 32'd0));
    end
    bus.in_valid = 1'b0;
    tick();
    check_output("drain valid", 32'(bus.out_valid), 32'd0);

    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(2'b00, OP_R, 3'b000, 7'b0, 32'(i), 32'(i));
      tick();
      check_output("b2b valid", 32'(bus.out_valid), 32'd1);
      check_output("b2b result", bus.result, 32'(2 * i));
    end
    bus.in_valid = 1'b0;
    tick();

    bus.out_ready = 1'b0;
    apply_stimulus(2'b00, OP_R, 3'b000, 7'b0, 32'd10, 32'd20);
    tick();
    apply_stimulus(2'b00, OP_R, 3'b000, 7'b0, 32'd7, 32'd8);
    for (int i = 0; i < 3; i++) begin
      check_output("stall in_ready", 32'(bus.in_ready), 32'd0);
      check_output("stall valid", 32'(bus.out_valid), 32'd1);
      check_output("stall result", bus.result, 32'd30);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check_output("release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check_output("after stall result", bus.result, 32'd15);
    check_output("after stall valid", 32'(bus.out_valid), 32'd1);
    tick();

    bus.out_ready = 1'b0;
    apply_stimulus(2'b00, OP_R, 3'b000, 7'b0, 32'd1, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("hold reset valid", 32'(bus.out_valid), 32'd0);
    check_output("hold reset result", bus.result, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

`ifdef ALU_MULDIV_EN
    run_md("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_md("divu by0", 3'b101, 32'h00001234, 32'd0, 32'hFFFFFFFF);
    run_md("rem by0", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    run_md("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_md("mul", 3'b000, 32'd6, 32'd7, 32'd42);
    run_md("mulh", 3'b001, 32'h80000000, 32'd2, 32'hFFFFFFFF);
    run_md("div neg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_md("rem neg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);

    apply_stimulus(2'b10, OP_R, 3'b100, 7'b0000001, 32'd100, 32'd3);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_output("busy reset valid", 32'(bus.out_valid), 32'd0);
    check_output("busy reset result", bus.result, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_output("busy reset in_ready", 32'(bus.in_ready), 32'd1);
    apply_stimulus(2'b00, OP_R, 3'b000, 7'b0, 32'd2, 32'd3);
    tick();
    bus.in_valid = 1'b0;
    check_output("post reset valid", 32'(bus.out_valid), 32'd1);
    check_output("post reset result", bus.result, 32'd5);
    tick();
`else
    apply_stimulus(2'b10, OP_R, 3'b000, 7'b0000001, 32'd6, 32'd7);
    tick();
    bus.in_valid = 1'b0;
    check_output("m-ext ignored valid", 32'(bus.out_valid), 32'd1);
    check_output("m-ext ignored result", bus.result, 32'h0000000D);
    check_output("m-ext ignored ctrl", 32'(bus.alu_ctrl), 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute stage that generalises the combinational ALU decoder into a handshaked decode-plus-execute unit. Decodes op/func3/func7/ALUOp, evaluates the full RV32I integer ALU set (adds XOR, SLTU and pass-B), and returns a registered result over valid/ready. Optionally adds an iterative RV32M multiply/divide path. Sits between the register-read stage and the memory/writeback stage of the core.

## Interface
- XLEN, 32, operand/result width; power of two, ≥8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- op  in  7  instruction opcode
- func3  in  3  instruction func3
- func7  in  7  instruction func7
- ALUOp  in  2  main-decoder class: 00 add, 01 sub, 10 func-decoded, 11 pass-B
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)
- alu_ctrl  out  5  registered decoded control of the held result

## Operation
- Accept on in_valid && in_ready; inputs sampled only at accept.
- Control codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101, SLL 00110, SLTU 00111, PASSB 01000, SRL 01001, SRA 01010.
- ALUOp 00 → ADD; 01 → SUB; 11 → PASSB (LUI).
- ALUOp 10, func3: 000 SUB iff op[5]&func7[5], else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA iff func7[5], else SRL (R- and I-type); 110 OR; 111 AND.
- Shifts use b[SHW-1:0]. SLT signed, SLTU unsigned; both yield 0/1 zero-extended. Add/sub wrap modulo 2^XLEN.
- States: IDLE, BUSY (multi-cycle only), HOLD (out_valid=1 awaiting out_ready).
- Single-cycle op: IDLE → HOLD. HOLD with out_ready: → HOLD if a new single-cycle op accepted same cycle, → BUSY if multi-cycle accepted, else → IDLE.
- in_ready = (state != BUSY) && (!out_valid || out_ready).
- result/zero/alu_ctrl stable while out_valid && !out_ready.

## Timing
- Reset: state IDLE, out_valid 0, result 0, zero 0, alu_ctrl 0, iteration counter 0, in_ready 1 after deassert.
- Single-cycle latency 1: accept at edge N → out_valid high after N+1. Throughput 1/cycle with out_ready held high.
- Multi-cycle (macro only): fixed latency XLEN+1 edges from accept to out_valid; in_ready 0 throughout BUSY; no early termination.
- Reset asserted mid-BUSY or in HOLD: immediate clear, in-flight result discarded.
- out_valid never drops without out_ready.

## Configuration
- ALU_MULDIV_EN defined: ALUOp 10 with op[5]=1 and func7=0000001 decodes by func3 to MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111. Shift-add multiplier and restoring divider, XLEN iterations each, shared counter. Div by zero: quotient all ones, remainder = a. Signed overflow (min / −1): quotient = min, remainder 0. Same fixed latency in both corner cases.
- Not defined: func7[0] ignored; those encodings decode as base ops (func7=0000001, func3=000 → ADD). No BUSY state; all ops single-cycle.

## Test plan
- ALUOp 10, op 0110011, func3 000, func7 0100000, a 5, b 7 → next cycle out_valid 1, result FFFFFFFE, alu_ctrl 00001, zero 0.
- func3 101, func7 0100000, a 80000000, b 4 → result F8000000 (SRA); func7 0 → 08000000 (SRL). SLT vs SLTU, a FFFFFFFF, b 1 → 1 vs 0.
- Back-to-back 4 ADDs, out_ready 1 → 4 results on consecutive cycles; out_ready low 3 cycles → result held, in_ready 0, no result lost.
- ALU_MULDIV_EN: DIV a 80000000, b FFFFFFFF → result 80000000 exactly 33 cycles after accept; DIVU b 0 → FFFFFFFF; REM b 0 → a; MULHU FFFFFFFF×FFFFFFFF → FFFFFFFE.
- rst_n low 10 cycles into a DIV → out_valid 0, result 0, in_ready 1 after release; next ADD 2+3 → 5 at latency 1.
- Without macro: func7 0000001, func3 000, a 6, b 7 → result 0000000D at latency 1.
